// File: rtl/checkout_payment.sv
// checkout_payment: payment/checkout stage of the scale-pricing transaction.
// Latches the order total on a checkout press, accumulates button-entered
// payments, and reports change (DONE) or a refund (REFUND) for a hold period.
// Optional feature macro: CHECKOUT_TIMEOUT_EN (auto-refund after an idle
// period in COLLECT). Without it, COLLECT waits indefinitely.
module checkout_payment #(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] total,
    input  logic [3:0]  item_count,
    input  logic        start,
    input  logic [3:0]  coin,
    input  logic        pay,
    input  logic        cancel,
    output logic [1:0]  state,
    output logic [15:0] due,
    output logic [15:0] paid,
    output logic [15:0] change,
    output logic [3:0]  items,
    output logic [3:0]  pay_count,
    output logic        done
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DONE    = 2'b10,
        REFUND  = 2'b11
    } state_t;

    state_t           state_q;
    logic             start_prev, pay_prev, cancel_prev;
    logic [CNT_W-1:0] hold_cnt;

    logic        start_ev, pay_ev, cancel_ev;
    logic        pay_ok, tmo_fire, refund_go, pay_covers;
    logic [15:0] coin_ext, paid_next;
    logic [16:0] paid_sum;

    assign state = state_q;

    // Button edge events and payment arithmetic shared by the FSM and timer.
    always_comb begin
        start_ev   = start & ~start_prev;
        pay_ev     = pay & ~pay_prev;
        cancel_ev  = cancel & ~cancel_prev;
        coin_ext   = 16'(coin);
        paid_sum   = {1'b0, paid} + 17'(coin_ext);
        paid_next  = paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
        pay_covers = (coin_ext >= due);
        pay_ok     = pay_ev && (coin != 4'd0) && !cancel_ev;
    end

`ifdef CHECKOUT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;

    // An accepted payment in the expiry cycle takes priority over the timeout.
    assign tmo_fire = (state_q == COLLECT) && (tmo_cnt == TMO_LAST) && !pay_ok;

    // Idle timer: restarts outside COLLECT and on every accepted payment.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state_q != COLLECT || pay_ok) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    assign refund_go = cancel_ev || tmo_fire;

    // Transaction FSM with registered outputs and button edge registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            due         <= '0;
            paid        <= '0;
            change      <= '0;
            items       <= '0;
            pay_count   <= '0;
            done        <= 1'b0;
            start_prev  <= 1'b0;
            pay_prev    <= 1'b0;
            cancel_prev <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            start_prev  <= start;
            pay_prev    <= pay;
            cancel_prev <= cancel;
            done        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ev && total != 16'd0) begin
                        state_q   <= COLLECT;
                        due       <= total;
                        items     <= item_count;
                        paid      <= '0;
                        change    <= '0;
                        pay_count <= '0;
                    end
                end
                COLLECT: begin
                    hold_cnt <= '0;
                    if (refund_go) begin
                        state_q <= REFUND;
                        change  <= paid;
                        due     <= '0;
                        done    <= 1'b1;
                    end else if (pay_ok) begin
                        paid <= paid_next;
                        if (pay_count != 4'hF) begin
                            pay_count <= pay_count + 4'd1;
                        end
                        if (pay_covers) begin
                            state_q <= DONE;
                            change  <= coin_ext - due;
                            due     <= '0;
                            done    <= 1'b1;
                        end else begin
                            due <= due - coin_ext;
                        end
                    end
                end
                default: begin
                    // DONE / REFUND: results frozen until the hold expires.
                    if (hold_cnt == HOLD_LAST) begin
                        state_q   <= IDLE;
                        hold_cnt  <= '0;
                        due       <= '0;
                        paid      <= '0;
                        change    <= '0;
                        pay_count <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
